gcd_unit_param: RTL
===================

GCD_UNIT_PARAM -- requirements
Module: gcd_unit_param

Interface
REQ-001: Parameter p_nbits, default 16, SHALL set operand/result width; legal values 2..64.
REQ-002: clk  input  1  clock; all state updates SHALL occur on posedge clk.
REQ-003: reset  input  1  reset, synchronous, active-high.
REQ-004: istream_val  input  1  request valid.
REQ-005: istream_rdy  output  1  request ready.
REQ-006: istream_msg  input  2*p_nbits  operand A in [2*p_nbits-1:p_nbits], operand B in [p_nbits-1:0].
REQ-007: ostream_val  output  1  response valid.
REQ-008: ostream_rdy  input  1  response ready.
REQ-009: ostream_msg  output  p_nbits  GCD result.
REQ-010: ostream_iters  output  16  iteration count of the current response; meaningful only while ostream_val=1.

Function
REQ-011: The FSM SHALL have states IDLE, CALC, DONE; the encoding is implementation choice.
REQ-012: IDLE: istream_rdy=1, ostream_val=0; on istream_val, the unit SHALL load A/B registers and the iteration counter SHALL clear to 0; next state CALC.
REQ-013: CALC: istream_rdy=0, ostream_val=0; each cycle exactly one action, in priority order:
 - B==0: no register update; next state DONE.
 - A<B (unsigned): swap (A<=B, B<=A); counter +1.
 - else: A<=A-B (p_nbits, unsigned, no overflow possible); counter +1.
REQ-014: DONE: ostream_val=1, ostream_msg=A; A/B and counter SHALL hold while ostream_rdy=0.
REQ-015: DONE with ostream_rdy=1 and istream_val=0: response consumed; next state IDLE.
REQ-016: DONE SHALL drive istream_rdy=ostream_rdy; with ostream_rdy=1 and istream_val=1, the response is consumed and a new request is loaded in the same cycle (counter cleared); next state CALC, with no idle bubble.
REQ-017: istream_rdy SHALL never depend combinationally on istream_val; ostream_val SHALL never depend on ostream_rdy.
REQ-018: Latency: request accept at cycle t -> ostream_val=1 at cycle t+N+2, where N = number of swap/subtract iterations.
REQ-019: A=0,B=0 SHALL produce result 0 with N=0; A=0,B=x SHALL produce x after one swap (N=1); A=x,B=0 SHALL produce x with N=0.
REQ-020: The iteration counter SHALL saturate at 16'hFFFF without wrapping.
REQ-021: istream_msg SHALL be sampled only in the accept cycle; changes at other times SHALL have no effect.

Reset
REQ-022: When reset is asserted, the FSM SHALL enter IDLE next cycle from any state, including mid-CALC and DONE; in-flight work is discarded.
REQ-023: During and after reset: istream_rdy=1 (IDLE), ostream_val=0; A, B and counter SHALL be 0.
REQ-024: No response SHALL be emitted for a request accepted before reset.

Configuration
REQ-025: Macro GCD_UNIT_PARAM_ITER_CNT_EN defined: ostream_iters SHALL carry the saturating iteration count per REQ-013/REQ-020.
REQ-026: Macro undefined: no counter register SHALL be synthesised, ostream_iters SHALL be tied to 0, and all other behaviour SHALL be identical.

Verification
REQ-027: p_nbits=16, req (15,5), ostream_rdy=1 -> resp 5, iters 4, ostream_val 6 cycles after accept.
REQ-028: p_nbits=16, req (27,15) -> resp 3, iters 9; ostream_rdy held 0 for 5 cycles in DONE -> msg/iters stable, then a single handshake.
REQ-029: Edge cases: (0,0) -> 0, iters 0; (0,7) -> 7, iters 1; (9,0) -> 9, iters 0; (FFFF,FFFF) -> FFFF, iters 2.
REQ-030: Back-to-back: (12,8) then (21,14) with istream_val always 1 and ostream_rdy=1 -> responses 4 then 7, second request accepted in the DONE cycle of the first.
REQ-031: Reset asserted during CALC of (1000,1) -> IDLE next cycle, ostream_val stays 0; a subsequent (6,4) -> 2.
REQ-032: p_nbits=32 random-pair sweep (1000 pairs, random ostream_rdy/istream_val stalls) against a golden model, run with and without GCD_UNIT_PARAM_ITER_CNT_EN (iters checked when the macro is defined, 0 when it is undefined).

Source files
------------

// File: rtl/gcd_unit_param.sv
// Iterative subtract/swap GCD with valid/ready streams and a back-to-back handshake.
// Define GCD_UNIT_PARAM_ITER_CNT_EN to expose a saturating per-response iteration count.
module gcd_unit_param #(
  parameter int p_nbits = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 istream_val,
  output logic                 istream_rdy,
  input  logic [2*p_nbits-1:0] istream_msg,
  output logic                 ostream_val,
  input  logic                 ostream_rdy,
  output logic [p_nbits-1:0]   ostream_msg,
  output logic [15:0]          ostream_iters
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nxt;
  logic [p_nbits-1:0] a, b, a_nxt, b_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
    end else begin
      state <= state_nxt;
      a     <= a_nxt;
      b     <= b_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    a_nxt       = a;
    b_nxt       = b;
    istream_rdy = 1'b0;
    ostream_val = 1'b0;
    case (state)
      IDLE: begin
        istream_rdy = 1'b1;
        if (istream_val) begin
          a_nxt     = istream_msg[2*p_nbits-1:p_nbits];
          b_nxt     = istream_msg[p_nbits-1:0];
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (b == '0) begin
          state_nxt = DONE;
        end else if (a < b) begin
          a_nxt = b;
          b_nxt = a;
        end else begin
          a_nxt = a - b;
        end
      end
      DONE: begin
        ostream_val = 1'b1;
        // Ready follows the consumer so a new request can overlap the drain cycle.
        istream_rdy = ostream_rdy;
        if (ostream_rdy) begin
          if (istream_val) begin
            a_nxt     = istream_msg[2*p_nbits-1:p_nbits];
            b_nxt     = istream_msg[p_nbits-1:0];
            state_nxt = CALC;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ostream_msg = a;

`ifdef GCD_UNIT_PARAM_ITER_CNT_EN
  logic [15:0] cnt;
  logic        load, step;

  assign load = istream_val && istream_rdy;
  assign step = (state == CALC) && (b != '0);

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= '0;
    else if (step && (cnt != 16'hFFFF))
      cnt <= cnt + 16'd1;
  end

  assign ostream_iters = cnt;
`else
  assign ostream_iters = '0;
`endif

endmodule
